// File: rtl/fp_mul_norm_round.sv
// fp_mul_norm_round
//   Back end of the iterative shift-add mantissa multiplier. Takes the raw
//   mantissa product, the product sign and the biased exponent sum. It shifts
//   the product left one bit per clock until the leading one reaches the top
//   bit, rounds to nearest-even and packs an IEEE-754 single-precision word.
//   Only one operation is in flight at a time.
//
// Ports
//   clk            clock, rising edge
//   reset          asynchronous active-high reset
//   in_valid       upstream product available
//   in_ready       block can accept a product (high only when idle)
//   in_sign        product sign
//   in_exp_sum     expA+expB-BIAS, 10-bit two's complement
//   in_prod        mantissa product; only bits [PW-1:0] are used
//   out_valid      result available (held until out_ready)
//   out_ready      downstream accepts the result
//   out_result     packed {sign, exponent, fraction}
//   out_overflow   result saturated to infinity
//   out_underflow  result flushed to zero
//   out_inexact    nonzero bits were discarded by rounding or flushing
module fp_mul_norm_round #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int BIAS   = 127
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic [9:0]                in_exp_sum,
  input  logic [63:0]               in_prod,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     out_result,
  output logic                      out_overflow,
  output logic                      out_underflow,
  output logic                      out_inexact
);

  localparam int MW = FRAC_W + 1;        // mantissa width incl. hidden bit
  localparam int PW = 2 * MW;            // meaningful product width
  localparam int CW = $clog2(PW);        // shift counter width
  localparam int EW = 12;                // internal signed exponent width
  // All-ones exponent of the IEEE format (reserved for Inf/NaN).
  localparam logic signed [EW-1:0] EXP_MAX = EW'(2 * BIAS + 1);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t                   state_reg;
  logic [PW-1:0]            m_reg;
  logic signed [EW-1:0]     e_reg;
  logic [CW-1:0]            cnt_reg;
  logic                     sign_reg;
  logic [EXP_W+FRAC_W:0]    result_reg;
  logic                     ovf_reg;
  logic                     unf_reg;
  logic                     inex_reg;

  // Rounding datapath, only meaningful while in ROUND.
  logic [MW-1:0]            kept;
  logic                     guard;
  logic                     sticky;
  logic                     round_up;
  logic [MW:0]              kept_inc;
  logic                     carry;
  logic signed [EW-1:0]     e_post;
  logic signed [EW-1:0]     e_load;
  logic                     unused_bits;

  assign e_load = {{(EW-10){in_exp_sum[9]}}, in_exp_sum} + EW'(1);

  // Product bits above PW carry no information; the top bit of the rounded
  // mantissa is the hidden one and is never packed.
  assign unused_bits = ^{in_prod[63:PW], kept_inc[MW-1]};

  always_comb begin
    kept     = m_reg[PW-1 -: MW];
    guard    = m_reg[PW-MW-1];
    sticky   = |m_reg[PW-MW-2:0];
    round_up = guard & (sticky | kept[0]);
    kept_inc = {1'b0, kept} + {{MW{1'b0}}, round_up};
    // A carry out means kept was all ones: the mantissa becomes 1.000...
    // (its fraction bits are already zero) and the exponent bumps by one.
    carry    = kept_inc[MW];
    e_post   = e_reg + $signed({{(EW-1){1'b0}}, carry});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      m_reg      <= '0;
      e_reg      <= '0;
      cnt_reg    <= '0;
      sign_reg   <= 1'b0;
      result_reg <= '0;
      ovf_reg    <= 1'b0;
      unf_reg    <= 1'b0;
      inex_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            m_reg    <= in_prod[PW-1:0];
            e_reg    <= e_load;
            sign_reg <= in_sign;
            cnt_reg  <= '0;
            if (in_prod[PW-1:0] == '0) begin
              result_reg <= {in_sign, {(EXP_W+FRAC_W){1'b0}}};
              ovf_reg    <= 1'b0;
              unf_reg    <= 1'b0;
              inex_reg   <= 1'b0;
              state_reg  <= DONE;
            end else begin
              state_reg  <= NORM;
            end
          end
        end
        NORM: begin
          // The counter test is a backstop only: a nonzero m always has its
          // leading one at the top by the time the counter reaches PW-1.
          if (m_reg[PW-1] || cnt_reg == CW'(PW - 1)) begin
            state_reg <= ROUND;
          end else begin
            m_reg   <= m_reg << 1;
            e_reg   <= e_reg - EW'(1);
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        ROUND: begin
          e_reg <= e_post;
          if (e_post >= EXP_MAX) begin
            result_reg <= {sign_reg, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            ovf_reg    <= 1'b1;
            unf_reg    <= 1'b0;
            inex_reg   <= 1'b1;
          end else if (e_post <= 0) begin
            result_reg <= {sign_reg, {(EXP_W+FRAC_W){1'b0}}};
            ovf_reg    <= 1'b0;
            unf_reg    <= 1'b1;
            inex_reg   <= 1'b1;
          end else begin
            result_reg <= {sign_reg, e_post[EXP_W-1:0], kept_inc[FRAC_W-1:0]};
            ovf_reg    <= 1'b0;
            unf_reg    <= 1'b0;
            inex_reg   <= guard | sticky;
          end
          state_reg <= DONE;
        end
        DONE: begin
          if (out_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready      = (state_reg == IDLE);
  assign out_valid     = (state_reg == DONE);
  assign out_result    = result_reg;
  assign out_overflow  = ovf_reg;
  assign out_underflow = unf_reg;
  assign out_inexact   = inex_reg;

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Testbench for fp_mul_norm_round. A driver issues directed vectors and pushes
// the hand-computed expected response into a scoreboard queue; a monitor pops
// and compares whenever the DUT completes an output handshake.
module tb_fp_mul_norm_round;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp_sum;
  logic [63:0] in_prod;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flags;   // {overflow, underflow, inexact}
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   first_cyc = 0;
  logic valid_prev = 1'b0;

  fp_mul_norm_round #(.EXP_W(8), .FRAC_W(23), .BIAS(127)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp_sum    (in_exp_sum),
    .in_prod       (in_prod),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_inexact   (out_inexact)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: latency is counted from the accept edge; valid first seen on the
  // falling edge after accept edge T counts as T+1.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !valid_prev) first_cyc = cyc;
    valid_prev = out_valid;
    if (out_valid && out_ready && !reset) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, out_result, e.res);
        check({e.name, "_flags"}, 32'({out_overflow, out_underflow, out_inexact}), 32'(e.flags));
        check({e.name, "_latency"}, 32'(first_cyc - e.acc + 1), 32'(e.lat));
        $display("txn %s: result=%h ovf=%b unf=%b inex=%b latency=%0d",
                 e.name, out_result, out_overflow, out_underflow, out_inexact,
                 first_cyc - e.acc + 1);
      end
    end
  end

  task automatic send(input logic [63:0] p, input logic [9:0] es, input logic s,
                      input logic [31:0] r, input logic [2:0] f, input int lat,
                      input string name);
    int n = 0;
    @(negedge clk);
    in_prod    = p;
    in_exp_sum = es;
    in_sign    = s;
    in_valid   = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check({name, "_in_ready_timeout"}, 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    sb.push_back('{res: r, flags: f, lat: lat, acc: cyc + 1, name: name});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_timeout"}, 32'(sb.size() != 0 || out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_sign    = 1'b0;
    in_exp_sum = '0;
    in_prod    = '0;
    out_ready  = 1'b1;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_result", out_result, 32'h0);
    check("reset_flags", 32'({out_overflow, out_underflow, out_inexact}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    send(64'h0000_9000_0000_0000, 10'd127, 1'b0, 32'h4010_0000, 3'b000, 3, "mul_1p5x1p5");
    drain("mul_1p5x1p5");
    send(64'h0000_4000_0000_0000, 10'd127, 1'b0, 32'h3F80_0000, 3'b000, 4, "mul_1x1");
    drain("mul_1x1");
    send(64'h0000_FFFF_FF80_0000, 10'd127, 1'b0, 32'h4080_0000, 3'b001, 3, "round_carry");
    drain("round_carry");
    send(64'h0000_FFFF_FE80_0000, 10'd127, 1'b0, 32'h407F_FFFE, 3'b001, 3, "tie_even_down");
    drain("tie_even_down");
    send(64'h0000_8000_0180_0000, 10'd127, 1'b0, 32'h4000_0002, 3'b001, 3, "round_up");
    drain("round_up");
    send(64'h0000_8000_0000_0001, 10'd127, 1'b0, 32'h4000_0000, 3'b001, 3, "sticky_only");
    drain("sticky_only");
    send(64'h0000_9000_0000_0000, 10'd254, 1'b1, 32'hFF80_0000, 3'b101, 3, "overflow");
    drain("overflow");
    send(64'h0000_FFFF_FF80_0000, 10'd253, 1'b0, 32'h7F80_0000, 3'b101, 3, "overflow_by_carry");
    drain("overflow_by_carry");
    send(64'h0000_4000_0000_0000, 10'h3FF, 1'b1, 32'h8000_0000, 3'b011, 4, "underflow");
    drain("underflow");
    send(64'h0000_0000_0000_0001, 10'd174, 1'b0, 32'h4000_0000, 3'b000, 50, "max_shift");
    drain("max_shift");

    // Zero product under backpressure; in_valid pulses must be ignored.
    out_ready = 1'b0;
    send(64'h0, 10'd5, 1'b1, 32'h8000_0000, 3'b000, 1, "zero_bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_result_stable", out_result, 32'h8000_0000);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      in_prod    = 64'h0000_9000_0000_0000;
      in_exp_sum = 10'd127;
      in_sign    = 1'b0;
      in_valid   = (i % 2) == 0;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("zero_bp");
    repeat (3) begin
      @(negedge clk);
      check("ignored_not_latched", 32'(out_valid), 32'd0);
    end

    // Reset in the middle of normalisation aborts the operation at once.
    send(64'h0000_0000_0000_0001, 10'd174, 1'b0, 32'h4000_0000, 3'b000, 50, "reset_abort");
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_result", out_result, 32'h0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;

    // Upper product bits are ignored; block works again after reset.
    send(64'hABCD_9000_0000_0000, 10'd127, 1'b0, 32'h4010_0000, 3'b000, 3, "after_reset");
    drain("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
